qam_sym_err_monitor: RTL and testbench

//  Parametrised measurement block for the QAM link. Generates sample/symbol clock enables from sys_clk.

---
 rtl/qam_meas_pkg.sv | 34 +++
 rtl/qam_sym_err_monitor_if.sv | 35 +++
 rtl/qam_clk_ena_gen.sv | 56 +++++
 rtl/qam_sym_err_monitor.sv | 164 ++++++++++++++++
 tb/tb_qam_sym_err_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_meas_pkg.sv
// Shared constants and width helpers for the QAM link measurement blocks.
// Default channel/symbol/error widths, channel index names and helpers
// that derive counter and accumulator widths from the block parameters.
package qam_meas_pkg;

  localparam int NCH_DEF      = 2;
  localparam int SYM_W_DEF    = 2;
  localparam int ERR_W_DEF    = 18;
  localparam int LOG2_WIN_DEF = 20;

  localparam int I_CH = 0;
  localparam int Q_CH = 1;

  // Error counters hold 0..2^log2_win inclusive, so one extra bit.
  function automatic int cnt_width(input int log2_win);
    return log2_win + 1;
  endfunction

  // Width of one squared error sample.
  function automatic int sq_width(input int err_w);
    return 2 * err_w;
  endfunction

  // Squared-error accumulator: a full window of squares never overflows.
  function automatic int sq_acc_width(input int err_w, input int log2_win);
    return 2 * err_w + log2_win;
  endfunction

  // Bits needed for a counter with n states (at least one bit).
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qam_sym_err_monitor_if.sv
// Signal bundle between the QAM link datapath and the symbol error monitor.
// master: drives run, symbols and error samples; slave: the monitor itself.
interface qam_sym_err_monitor_if
  import qam_meas_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int SYM_W    = SYM_W_DEF,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) ();

  logic                                 run;
  logic [NCH*SYM_W-1:0]                 ref_sym;
  logic [NCH*SYM_W-1:0]                 rx_sym;
  logic [NCH*ERR_W-1:0]                 err;
  logic                                 sam_clk_ena;
  logic                                 sym_clk_ena;
  logic                                 clear_accumulator;
  logic                                 result_valid;
  logic [NCH*cnt_width(LOG2_WIN)-1:0]   sym_err_count;
  logic [NCH*sq_width(ERR_W)-1:0]       err_power;

  modport master (
    output run, ref_sym, rx_sym, err,
    input  sam_clk_ena, sym_clk_ena, clear_accumulator, result_valid,
           sym_err_count, err_power
  );

  modport slave (
    input  run, ref_sym, rx_sym, err,
    output sam_clk_ena, sym_clk_ena, clear_accumulator, result_valid,
           sym_err_count, err_power
  );

endinterface

// File: rtl/qam_clk_ena_gen.sv
// Sample/symbol clock-enable generator. A free-running phase counter
// 0..SAMP_DIV*SPS-1, held as a sample sub-counter and a symbol sub-counter,
// decoded into one-cycle sample and symbol enables.
module qam_clk_ena_gen
  import qam_meas_pkg::*;
#(
  parameter int SAMP_DIV = 2,
  parameter int SPS      = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sam_clk_ena_o,
  output logic sym_clk_ena_o
);

  localparam int SAMP_CW = ctr_width(SAMP_DIV);
  localparam int SPS_CW  = ctr_width(SPS);
  localparam logic [SAMP_CW-1:0] SAMP_LAST = SAMP_CW'(SAMP_DIV - 1);
  localparam logic [SPS_CW-1:0]  SPS_LAST  = SPS_CW'(SPS - 1);

  logic [SAMP_CW-1:0] samp_q, samp_d;
  logic [SPS_CW-1:0]  sps_q, sps_d;
  logic               sam_wrap, sym_wrap;

  // phase = sps_q*SAMP_DIV + samp_q, so these match the phase decodes.
  assign sam_wrap = (samp_q == SAMP_LAST);
  assign sym_wrap = sam_wrap && (sps_q == SPS_LAST);

  assign sam_clk_ena_o = sam_wrap;
  assign sym_clk_ena_o = sym_wrap;

  // Next phase: advance the sample counter, carry into the symbol counter.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with a default assignment
    // first so no path leaves a signal unassigned (no latch); clocked
    // blocks use non-blocking '<=' only.
    samp_d = samp_q + SAMP_CW'(1);
    sps_d  = sps_q;
    if (sam_wrap) begin
      samp_d = '0;
      sps_d  = sym_wrap ? '0 : sps_q + SPS_CW'(1);
    end
  end

  // Phase registers; free-running regardless of measurement state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      sps_q  <= '0;
    end else begin
      samp_q <= samp_d;
      sps_q  <= sps_d;
    end
  end

endmodule

// File: rtl/qam_sym_err_monitor.sv
// QAM symbol error monitor. Delays the transmitted symbols by REF_DELAY
// symbols, compares them with slicer decisions per channel and publishes
// per-channel error counts every 2^LOG2_WIN compared symbols.
// Optional feature macro: ERR_POWER_EN adds per-channel mean squared error.
module qam_sym_err_monitor
  import qam_meas_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int SYM_W     = SYM_W_DEF,
  parameter int ERR_W     = ERR_W_DEF,
  parameter int SAMP_DIV  = 2,
  parameter int SPS       = 4,
  parameter int LOG2_WIN  = LOG2_WIN_DEF,
  parameter int REF_DELAY = 1
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  qam_sym_err_monitor_if.slave   bus
);

  localparam int CW      = cnt_width(LOG2_WIN);
  localparam int PW      = sq_width(ERR_W);
  localparam int AW      = sq_acc_width(ERR_W, LOG2_WIN);
  localparam int PRIME_W = ctr_width(REF_DELAY + 1);
  localparam logic [CW-1:0]      WIN_LAST   = CW'((1 << LOG2_WIN) - 1);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(REF_DELAY);

  logic               run;
  logic               sam_ena, sym_ena;
  logic               primed, cmp_ena, win_end;
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic [CW-1:0]      win_q, win_d;
  logic               result_valid_q;
  logic [NCH*CW-1:0]  cnt_flat;
  logic [NCH*PW-1:0]  pwr_flat;

  qam_clk_ena_gen #(
    .SAMP_DIV (SAMP_DIV),
    .SPS      (SPS)
  ) u_clk_ena (
    .clk           (sys_clk),
    .rst_n         (reset_n),
    .sam_clk_ena_o (sam_ena),
    .sym_clk_ena_o (sym_ena)
  );

  assign run     = bus.run;
  assign primed  = (prime_q == PRIME_DONE);
  assign cmp_ena = sym_ena && run && primed;
  assign win_end = cmp_ena && (win_q == WIN_LAST);

  assign bus.sam_clk_ena       = sam_ena;
  assign bus.sym_clk_ena       = sym_ena;
  assign bus.clear_accumulator = win_end;
  assign bus.result_valid      = result_valid_q;
  assign bus.sym_err_count     = cnt_flat;
  assign bus.err_power         = pwr_flat;

  // Priming and window position; both collapse to zero while run is low.
  always_comb begin
    prime_d = prime_q;
    win_d   = win_q;
    if (!run) begin
      prime_d = '0;
      win_d   = '0;
    end else begin
      if (sym_ena && !primed) prime_d = prime_q + PRIME_W'(1);
      if (win_end)            win_d   = '0;
      else if (cmp_ena)       win_d   = win_q + CW'(1);
    end
  end

  // Shared control registers and the result strobe.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_q        <= '0;
      win_q          <= '0;
      result_valid_q <= 1'b0;
    end else begin
      prime_q        <= prime_d;
      win_q          <= win_d;
      result_valid_q <= win_end;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SYM_W-1:0] ref_c, rx_c;
    logic [SYM_W-1:0] dly_q [REF_DELAY];
    logic             mism;
    logic [CW-1:0]    acc_q, acc_d, acc_sum, cnt_q;

    assign ref_c   = bus.ref_sym[c*SYM_W +: SYM_W];
    assign rx_c    = bus.rx_sym[c*SYM_W +: SYM_W];
    assign mism    = (dly_q[REF_DELAY-1] != rx_c);
    assign acc_sum = acc_q + CW'(mism);

    // Reference delay line, advanced once per symbol while measuring.
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: this small shift register is reset stage by stage so a
        // restart never compares against stale symbols; large storage
        // arrays elsewhere would normally be left without reset.
        for (int i = 0; i < REF_DELAY; i++) dly_q[i] <= '0;
      end else if (sym_ena && run) begin
        dly_q[0] <= ref_c;
        for (int i = 1; i < REF_DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    // Error accumulator: cleared when idle or at window end.
    always_comb begin
      acc_d = acc_q;
      if (!run || win_end) acc_d = '0;
      else if (cmp_ena)    acc_d = acc_sum;
    end

    // Accumulator and published per-window count (includes last symbol).
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_d;
        if (win_end) cnt_q <= acc_sum;
      end
    end

    assign cnt_flat[c*CW +: CW] = cnt_q;

`ifdef ERR_POWER_EN
    logic signed [ERR_W-1:0] err_c;
    logic signed [PW-1:0]    sq;
    logic [AW-1:0]           sq_acc_q, sq_acc_d, sq_sum;
    logic [PW-1:0]           pwr_q;

    assign err_c  = bus.err[c*ERR_W +: ERR_W];
    assign sq     = err_c * err_c;
    assign sq_sum = sq_acc_q + AW'($unsigned(sq));

    // Squared-error accumulator, same lifetime as the error accumulator.
    always_comb begin
      sq_acc_d = sq_acc_q;
      if (!run || win_end) sq_acc_d = '0;
      else if (cmp_ena)    sq_acc_d = sq_sum;
    end

    // Mean squared error published alongside the error count.
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        sq_acc_q <= '0;
        pwr_q    <= '0;
      end else begin
        sq_acc_q <= sq_acc_d;
        if (win_end) pwr_q <= PW'(sq_sum >> LOG2_WIN);
      end
    end

    assign pwr_flat[c*PW +: PW] = pwr_q;
`else
    assign pwr_flat[c*PW +: PW] = '0;
`endif
  end

endmodule

// File: tb/tb_qam_sym_err_monitor.sv
// Self-checking bench for qam_sym_err_monitor (NCH=2, SAMP_DIV=2, SPS=4,
// LOG2_WIN=4, REF_DELAY=1). Random symbols and errors are scored against a
// symbol-indexed window model kept in the bench.
module tb_qam_sym_err_monitor;
  import qam_meas_pkg::*;

  localparam int NCH       = 2;
  localparam int SYM_W     = 2;
  localparam int ERR_W     = 18;
  localparam int SAMP_DIV  = 2;
  localparam int SPS       = 4;
  localparam int LOG2_WIN  = 4;
  localparam int REF_DELAY = 1;
  localparam int CW        = LOG2_WIN + 1;
  localparam int PW        = 2 * ERR_W;
  localparam int WIN       = 1 << LOG2_WIN;
  localparam int SYM_PER   = SAMP_DIV * SPS;
  localparam int SW        = NCH * SYM_W;
  localparam int EW        = NCH * ERR_W;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  qam_sym_err_monitor_if #(
    .NCH(NCH), .SYM_W(SYM_W), .ERR_W(ERR_W), .LOG2_WIN(LOG2_WIN)
  ) bus ();

  qam_sym_err_monitor #(
    .NCH(NCH), .SYM_W(SYM_W), .ERR_W(ERR_W), .SAMP_DIV(SAMP_DIV),
    .SPS(SPS), .LOG2_WIN(LOG2_WIN), .REF_DELAY(REF_DELAY)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  string cur_test;

  // Reference model state: symbols since run rose, per-window tallies.
  int              sym_k;
  logic [SW-1:0]   ref_hist[$];
  int              win_err [NCH];
  longint          win_sq  [NCH];
  int              exp_cnt [NCH];
  longint          exp_pwr [NCH];
  logic [SW-1:0]   last_ref;

  task automatic model_clear_run();
    sym_k = 0;
    ref_hist.delete();
    for (int c = 0; c < NCH; c++) begin
      win_err[c] = 0;
      win_sq[c]  = 0;
    end
  endtask

  function automatic logic [NCH*CW-1:0] pack_cnt();
    logic [NCH*CW-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*CW +: CW] = CW'(exp_cnt[c]);
    return v;
  endfunction

  function automatic logic [NCH*PW-1:0] pack_pwr();
    logic [NCH*PW-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*PW +: PW] = PW'(exp_pwr[c]);
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_flip();
    logic [SW-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++)
      if ($urandom_range(0, 3) == 0) v[c*SYM_W +: SYM_W] = SYM_W'($urandom_range(1, 3));
    return v;
  endfunction

  function automatic logic [EW-1:0] mk_err(input int i_val, input int q_val);
    logic [EW-1:0] v;
    v = '0;
    v[I_CH*ERR_W +: ERR_W] = ERR_W'(i_val);
    v[Q_CH*ERR_W +: ERR_W] = ERR_W'(q_val);
    return v;
  endfunction

  function automatic logic [EW-1:0] rand_err();
    return mk_err(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
  endfunction

  // One symbol: wait for the symbol enable, drive inputs, predict and check.
  task automatic step_symbol(input logic run_v, input logic [SW-1:0] ref_v,
                             input logic [SW-1:0] rx_v, input logic [EW-1:0] err_v);
    bit                      found;
    bit                      exp_end;
    logic [SW-1:0]           delayed;
    logic signed [ERR_W-1:0] e_s;
    longint                  e;
    found = 1'b0;
    for (int i = 0; i < 2 * SYM_PER; i++) begin
      @(negedge sys_clk);
      if (bus.sym_clk_ena === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_chk++;
      $display("FAIL %s sym_clk_ena timeout: got none within %0d cycles, want one", cur_test, 2 * SYM_PER);
      return;
    end
    bus.run     = run_v;
    bus.ref_sym = ref_v;
    bus.rx_sym  = rx_v;
    bus.err     = err_v;
    #1;
    exp_end = 1'b0;
    if (!run_v) begin
      model_clear_run();
    end else begin
      if (sym_k >= REF_DELAY) begin
        delayed = ref_hist[sym_k - REF_DELAY];
        for (int c = 0; c < NCH; c++) begin
          if (delayed[c*SYM_W +: SYM_W] != rx_v[c*SYM_W +: SYM_W]) win_err[c]++;
          e_s = err_v[c*ERR_W +: ERR_W];
          e   = longint'(e_s);
          win_sq[c] += e * e;
        end
        if ((sym_k - REF_DELAY) % WIN == WIN - 1) begin
          exp_end = 1'b1;
          for (int c = 0; c < NCH; c++) begin
            exp_cnt[c] = win_err[c];
`ifdef ERR_POWER_EN
            exp_pwr[c] = win_sq[c] >>> LOG2_WIN;
`else
            exp_pwr[c] = 0;
`endif
            win_err[c] = 0;
            win_sq[c]  = 0;
          end
        end
      end
      ref_hist.push_back(ref_v);
      sym_k++;
    end
    n_chk++;
    if (bus.clear_accumulator !== exp_end)
      $display("FAIL %s clear_accumulator: got %b want %b (k=%0d)", cur_test, bus.clear_accumulator, exp_end, sym_k);
    else n_pass++;
    @(posedge sys_clk);
    #1;
    n_chk++;
    if (bus.result_valid !== exp_end)
      $display("FAIL %s result_valid: got %b want %b (k=%0d)", cur_test, bus.result_valid, exp_end, sym_k);
    else n_pass++;
    n_chk++;
    if (bus.sym_err_count !== pack_cnt())
      $display("FAIL %s sym_err_count: got %h want %h", cur_test, bus.sym_err_count, pack_cnt());
    else n_pass++;
    n_chk++;
    if (bus.err_power !== pack_pwr())
      $display("FAIL %s err_power: got %h want %h", cur_test, bus.err_power, pack_pwr());
    else n_pass++;
  endtask

  // Random reference symbol; rx is the previous reference with chosen flips.
  task automatic run_sym(input logic run_v, input logic [SW-1:0] flip, input logic [EW-1:0] err_v);
    logic [SW-1:0] ref_v;
    ref_v = SW'($urandom);
    step_symbol(run_v, ref_v, last_ref ^ flip, err_v);
    last_ref = ref_v;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    repeat (3) @(posedge sys_clk);
    #1;
    n_chk++;
    if ({bus.sam_clk_ena, bus.sym_clk_ena, bus.clear_accumulator, bus.result_valid,
         bus.sym_err_count, bus.err_power} !== '0)
      $display("FAIL reset outputs: got %b%b%b%b %h %h want all zero", bus.sam_clk_ena,
               bus.sym_clk_ena, bus.clear_accumulator, bus.result_valid, bus.sym_err_count, bus.err_power);
    else n_pass++;
  endtask

  task automatic test_enables();
    logic [1:0] exp_ena;
    cur_test = "enables";
    reset_n = 1'b1;
    for (int n = 1; n <= 3 * SYM_PER; n++) begin
      @(posedge sys_clk);
      #1;
      exp_ena = {(n % SYM_PER) == SYM_PER - 1, (n % SAMP_DIV) == SAMP_DIV - 1};
      n_chk++;
      if ({bus.sym_clk_ena, bus.sam_clk_ena} !== exp_ena)
        $display("FAIL enables cycle %0d {sym,sam}: got %b%b want %b", n, bus.sym_clk_ena, bus.sam_clk_ena, exp_ena);
      else n_pass++;
      n_chk++;
      if ({bus.clear_accumulator, bus.result_valid, bus.sym_err_count, bus.err_power} !== '0)
        $display("FAIL enables idle outputs cycle %0d: got nonzero want zero", n);
      else n_pass++;
    end
  endtask

  task automatic test_clean_window();
    cur_test = "clean_window";
    for (int i = 0; i < REF_DELAY + WIN; i++) run_sym(1'b1, '0, rand_err());
    n_chk++;
    if (bus.sym_err_count !== '0)
      $display("FAIL clean_window count: got %h want 0", bus.sym_err_count);
    else n_pass++;
  endtask

  task automatic test_q_errors();
    logic [SW-1:0] flip;
    cur_test = "q_errors";
    for (int j = 1; j <= WIN; j++) begin
      flip = '0;
      if (j == 2 || j == 9 || j == 16) flip[Q_CH*SYM_W +: SYM_W] = 2'b01;
      run_sym(1'b1, flip, rand_err());
    end
    n_chk++;
    if (bus.sym_err_count !== {5'd3, 5'd0})
      $display("FAIL q_errors count: got %h want %h", bus.sym_err_count, {5'd3, 5'd0});
    else n_pass++;
  endtask

  task automatic test_all_wrong();
    logic [SW-1:0] all_flip;
    cur_test = "all_wrong";
    all_flip = '1;
    for (int j = 0; j < WIN; j++) run_sym(1'b1, all_flip, rand_err());
    n_chk++;
    if (bus.sym_err_count !== {5'd16, 5'd16})
      $display("FAIL all_wrong count: got %h want %h", bus.sym_err_count, {5'd16, 5'd16});
    else n_pass++;
    for (int j = 0; j < WIN; j++) run_sym(1'b1, '0, rand_err());
    n_chk++;
    if (bus.sym_err_count !== '0)
      $display("FAIL all_wrong next window count: got %h want 0", bus.sym_err_count);
    else n_pass++;
    for (int j = 0; j < WIN; j++) run_sym(1'b1, all_flip, rand_err());
  endtask

  task automatic test_run_drop();
    cur_test = "run_drop";
    for (int j = 0; j < 10; j++) run_sym(1'b1, '1, rand_err());
    for (int j = 0; j < 3; j++) run_sym(1'b0, rand_flip(), rand_err());
    n_chk++;
    if (bus.sym_err_count !== {5'd16, 5'd16})
      $display("FAIL run_drop retained count: got %h want %h", bus.sym_err_count, {5'd16, 5'd16});
    else n_pass++;
    for (int j = 0; j < REF_DELAY + WIN; j++) run_sym(1'b1, rand_flip(), rand_err());
  endtask

  task automatic test_drop_at_end();
    cur_test = "drop_at_end";
    for (int j = 0; j < WIN - 1; j++) run_sym(1'b1, '1, rand_err());
    run_sym(1'b0, '1, rand_err());
    run_sym(1'b0, '0, rand_err());
    for (int j = 0; j < REF_DELAY + WIN; j++) run_sym(1'b1, '1, rand_err());
  endtask

  task automatic test_async_reset();
    cur_test = "async_reset";
    for (int j = 0; j < 5; j++) run_sym(1'b1, rand_flip(), rand_err());
    @(posedge sys_clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.sam_clk_ena, bus.sym_clk_ena, bus.clear_accumulator, bus.result_valid,
         bus.sym_err_count, bus.err_power} !== '0)
      $display("FAIL async_reset outputs: got count %h power %h want zero", bus.sym_err_count, bus.err_power);
    else n_pass++;
    model_clear_run();
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c] = 0;
      exp_pwr[c] = 0;
    end
    @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    for (int j = 0; j < REF_DELAY + WIN; j++) run_sym(1'b1, rand_flip(), rand_err());
  endtask

  task automatic test_err_power();
    logic [NCH*PW-1:0] want;
    cur_test = "err_power";
    for (int j = 0; j < WIN; j++) run_sym(1'b1, rand_flip(), mk_err(4, -3));
    want = '0;
`ifdef ERR_POWER_EN
    want[I_CH*PW +: PW] = PW'(16);
    want[Q_CH*PW +: PW] = PW'(9);
`endif
    n_chk++;
    if (bus.err_power !== want)
      $display("FAIL err_power value: got %h want %h", bus.err_power, want);
    else n_pass++;
  endtask

  initial begin
    bus.run     = 1'b0;
    bus.ref_sym = '0;
    bus.rx_sym  = '0;
    bus.err     = '0;
    last_ref    = '0;
    model_clear_run();
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c] = 0;
      exp_pwr[c] = 0;
    end
    test_reset();
    test_enables();
    test_clean_window();
    test_q_errors();
    test_all_wrong();
    test_run_drop();
    test_drop_at_end();
    test_async_reset();
    test_err_power();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
